cpu_fetch_queue: RTL
====================

// Module: cpu_fetch_queue
// PURPOSE
//  Prefetching instruction fetch unit between the memory port and the decoder.
//  Fetches 32-bit words sequentially from PC into a QUEUE_DEPTH-entry queue.
//  Hands words to the decoder over a valid/accept handshake.
//  Branch redirect flushes the queue and drops any stale in-flight word.
// PARAMETERS
//  QUEUE_DEPTH  4      queue entries; power of two, >= 2
//  RESET_PC     32'h0  fetch address after reset
//  PC_STEP      4      byte increment per sequential fetch
// PORTS
//  i_clock        in   1   clock, all state on rising edge
//  i_reset        in   1   asynchronous, active-low reset (0 = reset asserted)
//  i_branch       in   1   redirect strobe, one cycle
//  i_branch_pc    in   32  redirect target
//  o_pc           out  32  address of the next word to be requested
//  o_request      out  1   memory request, held until i_ready
//  o_address      out  32  memory address, stable while o_request=1
//  i_ready        in   1   memory completes the request; i_data valid this cycle
//  i_data         in   32  read data
//  o_instruction  out  32  queue head word
//  o_instr_pc     out  32  address of queue head word
//  o_fetched      out  1   queue head valid (queue not empty)
//  i_accept       in   1   decoder takes head when o_fetched=1
//  o_stall_count  out  32  only with CPU_FETCH_STATS_EN
// BEHAVIOUR
//  Reset (i_reset=0, async): o_pc=RESET_PC; o_request=0; o_address=0; o_instruction=0;
//   o_instr_pc=0; o_fetched=0; queue empty; state IDLE; o_stall_count=0.
//  States:
//   IDLE:    if count<QUEUE_DEPTH -> o_request<=1, o_address<=o_pc, go REQ.
//   REQ:     on i_ready: push {o_address,i_data}, o_pc<=o_pc+PC_STEP, o_request<=0, go IDLE.
//   DISCARD: on i_ready: drop i_data, o_request<=0, go IDLE. o_pc already holds redirect target.
//  Latency: request issued 1 cycle after entering IDLE with a free slot.
//   Word captured on i_ready is on o_fetched/o_instruction the next cycle.
//   Minimum 2 cycles per word with single outstanding request.
//  Decoder handshake: pop when o_fetched & i_accept. o_instruction/o_instr_pc hold while not accepted.
//   Push and pop in the same cycle are both honoured; count unchanged.
//  Full: no new request issued while count==QUEUE_DEPTH.
//   At most one request outstanding, so an issued request always has a slot.
//  Empty: o_fetched=0; i_accept ignored.
//  Redirect (i_branch=1), highest priority:
//   - Queue cleared; o_fetched=0 next cycle; a same-cycle pop is discarded.
//   - o_pc<=i_branch_pc.
//   - In REQ without i_ready: go DISCARD; o_request and o_address held until i_ready.
//   - In REQ with i_ready, or in IDLE: go IDLE; no push.
//   - In DISCARD: retarget o_pc only; remain in DISCARD.
//  Arithmetic: pointers are log2(QUEUE_DEPTH) bits and wrap modulo depth.
//   count is log2(QUEUE_DEPTH)+1 bits. PC adds wrap modulo 2^32.
// CONFIGURATION
//  CPU_FETCH_STATS_EN defined:
//   - o_stall_count increments each cycle o_fetched=0 and i_branch=0.
//   - Saturates at 32'hFFFFFFFF.
//   - Reset to 0; not cleared by redirect.
//  CPU_FETCH_STATS_EN undefined: port and counter absent; no other behavioural change.
// STRUCTURE
//  Shared package cpu_fetch_pkg:
//   - state enum {FETCH_IDLE, FETCH_REQ, FETCH_DISCARD}
//   - fetch_entry_t {addr[31:0], insn[31:0]}
//  Sub-module fetch_fifo:
//   - Parametrised by depth and entry width.
//   - Ports: push, pop, flush, head, full, empty, count.
//   - Holds storage and pointers; control FSM stays in the top.
// TESTING
//  1. Reset release, RESET_PC=0, memory i_ready 1 cycle after request, i_accept=1:
//     -> o_instr_pc 0,4,8,... in order; o_instruction equals memory contents.
//  2. i_accept=0 for 20 cycles, QUEUE_DEPTH=4:
//     -> exactly 4 requests (0,4,8,C); o_request stays 0; o_pc=0x10 until first accept.
//  3. i_branch to 0x100 while request to 0x8 awaits i_ready (ready 3 cycles later):
//     -> data for 0x8 dropped; o_fetched=0; next request address 0x100.
//  4. i_branch to 0x200 in the same cycle as i_ready and i_accept:
//     -> nothing pushed; queue empty; next request address 0x200.
//  5. Assert i_reset=0 mid-REQ, asynchronously between clock edges:
//     -> o_request=0 and o_fetched=0 immediately; after release first request to RESET_PC.
//  6. CPU_FETCH_STATS_EN defined, memory latency 3 cycles, decoder always accepting:
//     -> o_stall_count equals the number of o_fetched=0 cycles; reset to 0 by i_reset=0.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types for the prefetching fetch unit: control FSM states and the
// queue entry layout (word address paired with its instruction word).
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] insn;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer queue for fetched words: storage, wrap-around pointers and
// occupancy count. Flush empties it in one cycle and wins over push/pop.
module fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = FETCH_ENTRY_W
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    // A pop on an empty queue is ignored; a push into a full queue is only
    // accepted when a pop frees the head slot in the same cycle.
    always_comb begin
        pop_ok  = pop && (cnt != '0);
        push_ok = push && (!full || pop_ok);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= din;
    end

    always_comb begin
        head  = mem[rd_ptr];
        full  = (cnt == CNT_W'(DEPTH));
        empty = (cnt == '0);
        count = cnt;
    end

endmodule

// File: rtl/cpu_fetch_queue.sv
// Prefetching instruction fetch unit: single outstanding memory request, words
// queued for the decoder, branch redirect flush. Optional CPU_FETCH_STATS_EN.
module cpu_fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_branch,
    input  logic [31:0] i_branch_pc,
    output logic [31:0] o_pc,
    output logic        o_request,
    output logic [31:0] o_address,
    input  logic        i_ready,
    input  logic [31:0] i_data,
    output logic [31:0] o_instruction,
    output logic [31:0] o_instr_pc,
    output logic        o_fetched,
    input  logic        i_accept
`ifdef CPU_FETCH_STATS_EN
    ,
    output logic [31:0] o_stall_count
`endif
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [31:0]      pc_next;
    logic             request_next;
    logic [31:0]      address_next;

    logic             push;
    logic             pop;
    logic             flush;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .push    (push),
        .din     (push_entry),
        .pop     (pop),
        .flush   (flush),
        .head    (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            state <= FETCH_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_pc      <= RESET_PC;
            o_request <= 1'b0;
            o_address <= '0;
        end else begin
            o_pc      <= pc_next;
            o_request <= request_next;
            o_address <= address_next;
        end
    end

    // Redirect takes priority in every state; an in-flight request must still
    // complete on the memory port, so it is parked in DISCARD until i_ready.
    always_comb begin
        state_next   = state;
        pc_next      = o_pc;
        request_next = o_request;
        address_next = o_address;
        case (state)
            FETCH_IDLE: begin
                if (i_branch) begin
                    pc_next = i_branch_pc;
                end else if (!fifo_full) begin
                    request_next = 1'b1;
                    address_next = o_pc;
                    state_next   = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (i_branch) begin
                    pc_next = i_branch_pc;
                    if (i_ready) begin
                        request_next = 1'b0;
                        state_next   = FETCH_IDLE;
                    end else begin
                        state_next   = FETCH_DISCARD;
                    end
                end else if (i_ready) begin
                    pc_next      = o_pc + PC_STEP;
                    request_next = 1'b0;
                    state_next   = FETCH_IDLE;
                end
            end
            FETCH_DISCARD: begin
                if (i_branch)
                    pc_next = i_branch_pc;
                if (i_ready) begin
                    request_next = 1'b0;
                    state_next   = FETCH_IDLE;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_comb begin
        flush      = i_branch;
        push       = (state == FETCH_REQ) && i_ready && !i_branch;
        push_entry = '{addr: o_address, insn: i_data};
        o_fetched  = (fifo_count != '0);
        pop        = o_fetched && i_accept && !i_branch;
        // Empty queue presents zeros rather than stale storage.
        o_instruction = fifo_empty ? '0 : head_entry.insn;
        o_instr_pc    = fifo_empty ? '0 : head_entry.addr;
    end

`ifdef CPU_FETCH_STATS_EN
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            o_stall_count <= '0;
        else if (!o_fetched && !i_branch && (o_stall_count != '1))
            o_stall_count <= o_stall_count + 32'd1;
    end
`endif

endmodule
